// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - N-bit up/down Gray counter with load, sticky over/underflow flags and wrap pulse
// Binary count is the state of record; the Gray view is recomputed from the next binary value and registered alongside it.

module gray_counter_n #(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_clr_flags,
    output logic [WIDTH-1:0] o_output,
    output logic [WIDTH-1:0] o_binary,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_ovf_step;
    logic             w_unf_step;

    always_comb begin
        w_next_bin = r_bin;
        w_ovf_step = 1'b0;
        w_unf_step = 1'b0;
        if (i_load) begin
            w_next_bin = i_load_val;
        end else if (i_en) begin
            if (i_up) begin
                if (r_bin == MAX) begin
                    w_ovf_step = 1'b1;
                    w_next_bin = SATURATE ? MAX : ZERO;
                end else begin
                    w_next_bin = r_bin + ONE;
                end
            end else begin
                if (r_bin == ZERO) begin
                    w_unf_step = 1'b1;
                    w_next_bin = SATURATE ? ZERO : MAX;
                end else begin
                    w_next_bin = r_bin - ONE;
                end
            end
        end
        w_next_gray = w_next_bin ^ (w_next_bin >> 1);
    end

    // A flag being set in the same cycle as ClrFlags must survive the clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bin       <= ZERO;
            r_gray      <= ZERO;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_bin       <= w_next_bin;
            r_gray      <= w_next_gray;
            r_overflow  <= w_ovf_step | (r_overflow & ~i_clr_flags);
            r_underflow <= w_unf_step | (r_underflow & ~i_clr_flags);
            r_wrap      <= w_ovf_step | w_unf_step;
        end
    end

    assign o_output    = r_gray;
    assign o_binary    = r_bin;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
    assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb/tb_gray_counter_n.sv - directed table-driven bench for gray_counter_n (wrapping, saturating and 8-bit instances)

module tb_gray_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       reset;
        logic       en;
        logic       up;
        logic       load;
        logic [2:0] lv;
        logic       clr;
        logic [2:0] bin;
        logic [2:0] gray;
        logic       ovf;
        logic       unf;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    int total = 0;
    int bad   = 0;

    // instance A: WIDTH=3 wrapping
    logic       a_reset = 1'b1, a_en = 1'b0, a_up = 1'b0, a_load = 1'b0, a_clr = 1'b0;
    logic [2:0] a_lv = 3'd0;
    logic [2:0] a_gray, a_bin;
    logic       a_ovf, a_unf, a_wrap;

    // instance B: WIDTH=3 saturating
    logic       b_reset = 1'b1, b_en = 1'b0, b_up = 1'b0, b_load = 1'b0, b_clr = 1'b0;
    logic [2:0] b_lv = 3'd0;
    logic [2:0] b_gray, b_bin;
    logic       b_ovf, b_unf, b_wrap;

    // instance C: WIDTH=8 wrapping
    logic       c_reset = 1'b1, c_en = 1'b0, c_up = 1'b0, c_load = 1'b0, c_clr = 1'b0;
    logic [7:0] c_lv = 8'd0;
    logic [7:0] c_gray, c_bin;
    logic       c_ovf, c_unf, c_wrap;

    gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) u_a (
        .i_clk(clk), .i_reset(a_reset), .i_en(a_en), .i_up(a_up), .i_load(a_load),
        .i_load_val(a_lv), .i_clr_flags(a_clr), .o_output(a_gray), .o_binary(a_bin),
        .o_overflow(a_ovf), .o_underflow(a_unf), .o_wrap(a_wrap)
    );

    gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) u_b (
        .i_clk(clk), .i_reset(b_reset), .i_en(b_en), .i_up(b_up), .i_load(b_load),
        .i_load_val(b_lv), .i_clr_flags(b_clr), .o_output(b_gray), .o_binary(b_bin),
        .o_overflow(b_ovf), .o_underflow(b_unf), .o_wrap(b_wrap)
    );

    gray_counter_n #(.WIDTH(8), .SATURATE(1'b0)) u_c (
        .i_clk(clk), .i_reset(c_reset), .i_en(c_en), .i_up(c_up), .i_load(c_load),
        .i_load_val(c_lv), .i_clr_flags(c_clr), .o_output(c_gray), .o_binary(c_bin),
        .o_overflow(c_ovf), .o_underflow(c_unf), .o_wrap(c_wrap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic en, input logic up, input logic ld,
                                input logic [2:0] lv, input logic clr, input logic [2:0] bin,
                                input logic [2:0] gray, input logic ovf, input logic unf,
                                input logic wrap);
        vec_t v;
        v.reset = r; v.en = en; v.up = up; v.load = ld; v.lv = lv; v.clr = clr;
        v.bin = bin; v.gray = gray; v.ovf = ovf; v.unf = unf; v.wrap = wrap;
        vecs.push_back(v);
    endfunction

    task automatic step_b(input logic en, input logic up, input logic ld, input logic [2:0] lv,
                          input logic [2:0] bin, input logic [2:0] gray, input logic ovf,
                          input logic unf, input logic wrap, input string name);
        b_en = en; b_up = up; b_load = ld; b_lv = lv;
        @(posedge clk); #1;
        chk({name, ".bin"},  b_bin,  bin);
        chk({name, ".gray"}, b_gray, gray);
        chk({name, ".ovf"},  b_ovf,  ovf);
        chk({name, ".unf"},  b_unf,  unf);
        chk({name, ".wrap"}, b_wrap, wrap);
    endtask

    initial begin
        //  r  en up ld lv    clr bin   gray   ovf unf wrap
        add(1, 0, 0, 0, 3'd0, 0, 3'd0, 3'b000, 0, 0, 0);
        add(1, 0, 0, 0, 3'd0, 0, 3'd0, 3'b000, 0, 0, 0);
        add(1, 0, 0, 0, 3'd0, 0, 3'd0, 3'b000, 0, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd1, 3'b001, 0, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd2, 3'b011, 0, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd3, 3'b010, 0, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd4, 3'b110, 0, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd5, 3'b111, 0, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd6, 3'b101, 0, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd7, 3'b100, 0, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd0, 3'b000, 1, 0, 1);
        add(0, 1, 1, 0, 3'd0, 0, 3'd1, 3'b001, 1, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd2, 3'b011, 1, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd3, 3'b010, 1, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd4, 3'b110, 1, 0, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd5, 3'b111, 1, 0, 0);
        add(0, 1, 1, 1, 3'd5, 0, 3'd5, 3'b111, 1, 0, 0);
        add(0, 1, 0, 0, 3'd0, 0, 3'd4, 3'b110, 1, 0, 0);
        add(0, 1, 0, 0, 3'd0, 0, 3'd3, 3'b010, 1, 0, 0);
        add(0, 1, 0, 0, 3'd0, 0, 3'd2, 3'b011, 1, 0, 0);
        add(0, 1, 0, 0, 3'd0, 0, 3'd1, 3'b001, 1, 0, 0);
        add(0, 1, 0, 0, 3'd0, 0, 3'd0, 3'b000, 1, 0, 0);
        add(0, 1, 0, 0, 3'd0, 0, 3'd7, 3'b100, 1, 1, 1);
        add(0, 0, 0, 0, 3'd0, 0, 3'd7, 3'b100, 1, 1, 0);
        add(0, 0, 0, 0, 3'd0, 1, 3'd7, 3'b100, 0, 0, 0);
        add(0, 1, 1, 0, 3'd0, 1, 3'd0, 3'b000, 1, 0, 1);
        add(0, 1, 0, 0, 3'd0, 1, 3'd7, 3'b100, 0, 1, 1);
        add(0, 1, 1, 0, 3'd0, 0, 3'd0, 3'b000, 1, 1, 1);
        add(0, 1, 0, 0, 3'd0, 0, 3'd7, 3'b100, 1, 1, 1);
        add(0, 1, 0, 1, 3'd5, 0, 3'd5, 3'b111, 1, 1, 0);
        add(0, 1, 1, 0, 3'd0, 0, 3'd6, 3'b101, 1, 1, 0);
        add(1, 1, 1, 1, 3'd3, 0, 3'd0, 3'b000, 0, 0, 0);
        add(0, 0, 1, 0, 3'd0, 0, 3'd0, 3'b000, 0, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            a_reset = vecs[i].reset; a_en = vecs[i].en; a_up = vecs[i].up;
            a_load = vecs[i].load; a_lv = vecs[i].lv; a_clr = vecs[i].clr;
            @(posedge clk); #1;
            chk($sformatf("a[%0d].bin", i),  a_bin,  vecs[i].bin);
            chk($sformatf("a[%0d].gray", i), a_gray, vecs[i].gray);
            chk($sformatf("a[%0d].ovf", i),  a_ovf,  vecs[i].ovf);
            chk($sformatf("a[%0d].unf", i),  a_unf,  vecs[i].unf);
            chk($sformatf("a[%0d].wrap", i), a_wrap, vecs[i].wrap);
        end

        // saturating instance: blocked steps hold the end value and pulse wrap each time
        b_reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            b_en = 1'b1; b_up = 1'b1;
            @(posedge clk); #1;
        end
        chk("b.reach7", b_bin, 3'd7);
        step_b(1, 1, 0, 3'd0, 3'd7, 3'b100, 1, 0, 1, "b.sat1");
        step_b(1, 1, 0, 3'd0, 3'd7, 3'b100, 1, 0, 1, "b.sat2");
        step_b(1, 1, 0, 3'd0, 3'd7, 3'b100, 1, 0, 1, "b.sat3");
        step_b(0, 1, 0, 3'd0, 3'd7, 3'b100, 1, 0, 0, "b.idle");
        step_b(1, 0, 0, 3'd0, 3'd6, 3'b101, 1, 0, 0, "b.down");
        step_b(0, 0, 1, 3'd0, 3'd0, 3'b000, 1, 0, 0, "b.load0");
        step_b(1, 0, 0, 3'd0, 3'd0, 3'b000, 1, 1, 1, "b.unfsat");
        step_b(1, 1, 0, 3'd0, 3'd1, 3'b001, 1, 1, 0, "b.resume");

        // 8-bit sweep: 256 up steps, exactly one gray bit changes per step
        c_reset = 1'b0; c_en = 1'b1; c_up = 1'b1;
        begin
            logic [7:0] prev_gray;
            logic [7:0] exp_bin;
            logic [7:0] diff;
            prev_gray = 8'd0;
            for (int s = 1; s <= 256; s++) begin
                @(posedge clk); #1;
                exp_bin = 8'(s);
                diff = c_gray ^ prev_gray;
                chk($sformatf("c[%0d].bin", s), c_bin, exp_bin);
                chk($sformatf("c[%0d].gray", s), c_gray, exp_bin ^ (exp_bin >> 1));
                chk($sformatf("c[%0d].onebit", s), $countones(diff), 1);
                chk($sformatf("c[%0d].ovf", s), c_ovf, (s == 256) ? 1'b1 : 1'b0);
                chk($sformatf("c[%0d].wrap", s), c_wrap, (s == 256) ? 1'b1 : 1'b0);
                prev_gray = c_gray;
            end
        end
        c_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
